wb_reg_slave: RTL and testbench
===============================

Name: wb_reg_slave

Overview:
Parametrised Wishbone classic slave that holds NREGS read/write 32-bit registers and two read-only transaction counters.
- Features: byte-lane writes, configurable wait states, ERR response for illegal accesses, abort on CYC drop.
- Sits on the shared Wishbone bus as a generic control/status target.
- Used as the standard bus-test and configuration slave in place of always-ack stubs.

Parameters:
NREGS, 8, number of read/write registers (1..64)
WAIT_STATES, 0, cycles inserted between request capture and response (0..15)
RST_VAL, 32'h0, reset value of every read/write register

Ports:
p_clk  in  1  clock, all logic on rising edge
p_reset  in  1  synchronous active-high reset
p_wb_DAT_I  in  32  write data
p_wb_DAT_O  out  32  read data, valid only while ACK is high
p_wb_ADR_I  in  32  byte address; word index = ADR_I[31:2]
p_wb_ACK_O  out  1  normal termination, one-cycle pulse
p_wb_CYC_I  in  1  bus cycle valid
p_wb_ERR_O  out  1  error termination, one-cycle pulse
p_wb_LOCK_I  in  1  ignored
p_wb_RTY_O  out  1  tied 0
p_wb_SEL_I  in  4  byte lane enables; bit n selects DAT[8n+7:8n]
p_wb_STB_I  in  1  strobe
p_wb_WE_I  in  1  1 = write, 0 = read

Behaviour:
- Reset (p_reset=1 at a rising edge):
  - FSM goes to IDLE.
  - All registers load RST_VAL; WCNT and RCNT load 0.
  - ACK_O, ERR_O and DAT_O are 0 and stay 0 on the following cycle.
  - Reset mid-transfer discards the transfer with no response and no register or counter update.
- Address map (word index):
  - 0..NREGS-1: read/write registers.
  - NREGS: WCNT, read-only.
  - NREGS+1: RCNT, read-only.
  - Any higher index is illegal.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on CYC&STB=1, capture ADR, WE, SEL and DAT_I.
    - If WAIT_STATES=0, go to RESP; else load wait counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: if CYC=0, abort to IDLE (no write, no count, no response). If counter=0 go to RESP, else decrement.
  - RESP: drive exactly one of ACK_O/ERR_O high for one cycle, then return to IDLE.
    - If CYC has dropped on entry to RESP, the response is still driven and the master ignores it.
- Latency: ACK/ERR is high on cycle WAIT_STATES+1 after the first cycle with CYC&STB sampled high.
- Back-to-back: IDLE needs one cycle, so STB held high produces a new transfer every WAIT_STATES+2 cycles.
- Write to a legal R/W register: applied on the RESP edge.
  - Each byte with SEL[n]=1 takes DAT_I; SEL=0 bytes are unchanged.
  - SEL=4'b0000 still ACKs, writes nothing, and counts.
- Read of a legal index: DAT_O = full 32-bit word during the RESP cycle (SEL ignored on reads); DAT_O=0 in every other cycle.
- ERR cases, with no state change, no count, and DAT_O=0:
  - Write to WCNT or RCNT.
  - Any access to an illegal index.
- Counters:
  - WCNT increments on every ACKed write; RCNT on every ACKed read.
  - Both are 32-bit and wrap 0xFFFFFFFF -> 0.
  - A read of RCNT returns the value before its own increment.
- LOCK_I has no effect; RTY_O is constant 0.

Test Plan:
- Reset then read index 0, NREGS=8, RST_VAL=0 -> ACK one cycle after STB, DAT_O=0x00000000, RCNT=1.
- Write 0xA5A5A5A5 with SEL=4'hF to index 3, then write 0x00001234 with SEL=4'b0011 to index 3, then read index 3 -> DAT_O=0xA5A51234; read index 8 (WCNT) -> 2.
- Write to index 9 (RCNT) or index 10 -> ERR_O pulse, ACK_O=0, WCNT and RCNT unchanged.
- WAIT_STATES=3, read index 0 -> ACK on the 4th cycle after STB; drop CYC in the 2nd wait cycle of a write -> no ACK, register and WCNT unchanged.
- STB/CYC held high for 4 reads with WAIT_STATES=0 -> ACK pulses every 2nd cycle, RCNT advances 0->4.
- Assert p_reset during the WAIT state of a write to index 1 -> no ACK, index 1 = RST_VAL, WCNT=0, next transfer completes normally.

Source files
------------

// File: rtl/wb_reg_slave_if.sv
// Wishbone classic bus bundle between one master and the wb_reg_slave target.
// Signal names keep the Wishbone suffixes so the instance reads as p_wb.ACK_O etc.
interface wb_reg_slave_if;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [31:0] ADR_I;
  logic        ACK_O;
  logic        CYC_I;
  logic        ERR_O;
  logic        LOCK_I;
  logic        RTY_O;
  logic [3:0]  SEL_I;
  logic        STB_I;
  logic        WE_I;

  modport slave (
    input  DAT_I, ADR_I, CYC_I, LOCK_I, SEL_I, STB_I, WE_I,
    output DAT_O, ACK_O, ERR_O, RTY_O
  );

  modport master (
    output DAT_I, ADR_I, CYC_I, LOCK_I, SEL_I, STB_I, WE_I,
    input  DAT_O, ACK_O, ERR_O, RTY_O
  );
endinterface

// File: rtl/wb_reg_slave.sv
// Wishbone classic register slave: NREGS byte-writable R/W registers plus
// read-only write/read transaction counters, optional wait states, ERR on
// illegal accesses and abort when CYC drops while waiting.
// All outputs come straight from flops; the response is decided on the edge
// that enters RESP, and register/counter updates happen on that same edge.
module wb_reg_slave #(
  parameter int          NREGS       = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RST_VAL     = 32'h0
) (
  input  logic            p_clk,
  input  logic            p_reset,
  wb_reg_slave_if.slave   p_wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word indices of the two counters; anything at or above IDX_WCNT is not a R/W register.
  localparam logic [29:0] IDX_WCNT  = 30'(NREGS);
  localparam logic [29:0] IDX_RCNT  = 30'(NREGS + 1);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  // Merge new data into an old word, byte lane by byte lane.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [29:0] idx_q, idx_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_o_q, dat_o_d;

  logic [29:0] req_idx_s;
  logic        req_we_s;
  logic [3:0]  req_sel_s;
  logic [31:0] req_wdat_s;
  logic        hit_reg_s;
  logic        hit_wcnt_s;
  logic        hit_rcnt_s;
  logic [31:0] rd_word_s;
  logic        unused_s;

  assign unused_s = ^{p_wb.LOCK_I, p_wb.ADR_I[1:0]};

  // Request view: live bus when responding straight from IDLE, captured copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      req_idx_s  = p_wb.ADR_I[31:2];
      req_we_s   = p_wb.WE_I;
      req_sel_s  = p_wb.SEL_I;
      req_wdat_s = p_wb.DAT_I;
    end else begin
      req_idx_s  = idx_q;
      req_we_s   = we_q;
      req_sel_s  = sel_q;
      req_wdat_s = wdat_q;
    end
  end

  // Address decode and read-data mux for the current request.
  always_comb begin
    hit_reg_s  = (req_idx_s < IDX_WCNT);
    hit_wcnt_s = (req_idx_s == IDX_WCNT);
    hit_rcnt_s = (req_idx_s == IDX_RCNT);
    rd_word_s  = 32'h0;
    for (int i = 0; i < NREGS; i++) begin
      rd_word_s = (req_idx_s == 30'(i)) ? regs_q[i] : rd_word_s;
    end
    rd_word_s = hit_wcnt_s ? wcnt_q : rd_word_s;
    rd_word_s = hit_rcnt_s ? rcnt_q : rd_word_s;
  end

  // Next-state logic: FSM sequencing, response decision and register/counter updates.
  always_comb begin
    logic go_resp;
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    regs_d  = regs_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_o_d = 32'h0;
    go_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (p_wb.CYC_I && p_wb.STB_I) begin
          idx_d  = p_wb.ADR_I[31:2];
          we_d   = p_wb.WE_I;
          sel_d  = p_wb.SEL_I;
          wdat_d = p_wb.DAT_I;
          if (WAIT_STATES == 0) begin
            go_resp = 1'b1;
          end else begin
            wait_d  = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!p_wb.CYC_I) begin
          state_d = ST_IDLE;
        end else if (wait_q == 4'd0) begin
          go_resp = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_resp) begin
      state_d = ST_RESP;
      if (req_we_s) begin
        if (hit_reg_s) begin
          ack_d  = 1'b1;
          wcnt_d = wcnt_q + 32'd1;
          for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = (req_idx_s == 30'(i)) ?
                        merge_bytes(regs_q[i], req_wdat_s, req_sel_s) : regs_q[i];
          end
        end else begin
          err_d = 1'b1;
        end
      end else begin
        if (hit_reg_s || hit_wcnt_s || hit_rcnt_s) begin
          ack_d   = 1'b1;
          dat_o_d = rd_word_s;
          rcnt_d  = rcnt_q + 32'd1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      ack_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      idx_q   <= 30'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'h0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RST_VAL;
      end
      wcnt_q  <= 32'h0;
      rcnt_q  <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_o_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      regs_q  <= regs_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_o_q <= dat_o_d;
    end
  end

  assign p_wb.ACK_O = ack_q;
  assign p_wb.ERR_O = err_q;
  assign p_wb.DAT_O = dat_o_q;
  assign p_wb.RTY_O = 1'b0;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Directed bench for wb_reg_slave: one instance with no wait states driven
// from a vector table, one with three wait states for the multi-cycle cases.
module tb_wb_reg_slave;

  logic p_clk;
  logic p_reset;

  wb_reg_slave_if bus0 ();
  wb_reg_slave_if bus3 ();

  wb_reg_slave #(.NREGS(8), .WAIT_STATES(0), .RST_VAL(32'h0)) dut0 (
    .p_clk(p_clk), .p_reset(p_reset), .p_wb(bus0)
  );

  wb_reg_slave #(.NREGS(8), .WAIT_STATES(3), .RST_VAL(32'h0)) dut3 (
    .p_clk(p_clk), .p_reset(p_reset), .p_wb(bus3)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit use3, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (use3) begin
      bus3.CYC_I = cyc; bus3.STB_I = stb; bus3.WE_I = we;
      bus3.ADR_I = adr; bus3.SEL_I = sel; bus3.DAT_I = dat;
    end else begin
      bus0.CYC_I = cyc; bus0.STB_I = stb; bus0.WE_I = we;
      bus0.ADR_I = adr; bus0.SEL_I = sel; bus0.DAT_I = dat;
    end
  endtask

  task automatic sample(input bit use3, output logic ack, output logic err, output logic [31:0] dat);
    if (use3) begin
      ack = bus3.ACK_O; err = bus3.ERR_O; dat = bus3.DAT_O;
    end else begin
      ack = bus0.ACK_O; err = bus0.ERR_O; dat = bus0.DAT_O;
    end
  endtask

  // One complete transfer: returns the response and the cycles until it appeared,
  // and checks the outputs are quiet on the cycle after the response pulse.
  task automatic xfer(input bit use3, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat,
                      output logic got_ack, output logic got_err,
                      output logic [31:0] got_dat, output int lat);
    logic a, e;
    logic [31:0] d;
    @(negedge p_clk);
    drive(use3, 1'b1, 1'b1, we, adr, sel, dat);
    lat = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0;
    while (lat < 20 && !(got_ack || got_err)) begin
      @(posedge p_clk); #1;
      lat++;
      sample(use3, got_ack, got_err, got_dat);
    end
    drive(use3, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("response_seen", {31'd0, got_ack | got_err}, 32'd1);
    @(posedge p_clk); #1;
    sample(use3, a, e, d);
    chk("quiet_after_resp", {a, e, d[29:0]}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge p_clk);
    p_reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge p_clk);
    @(negedge p_clk);
    p_reset = 1'b0;
  endtask

  // Expect a given read result with a given latency on one instance.
  task automatic rd_expect(input bit use3, input string name, input logic [31:0] adr,
                           input logic [31:0] exp, input int exp_lat);
    logic a, e;
    logic [31:0] d;
    int l;
    xfer(use3, 1'b0, adr, 4'hF, 32'h0, a, e, d, l);
    chk({name, "_ack"}, {31'd0, a}, 32'd1);
    chk({name, "_dat"}, d, exp);
    chk({name, "_lat"}, 32'(l), 32'(exp_lat));
  endtask

  initial begin
    logic a, e;
    logic [31:0] d;
    int l;
    n_vec = 0;
    n_err = 0;
    p_reset = 1'b0;
    bus0.LOCK_I = 1'b0;
    bus3.LOCK_I = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    //                we    adr           sel      dat           ack   err   rdat
    vt[0]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
    vt[1]  = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0001};
    vt[2]  = '{1'b1, 32'h0000_000C, 4'hF, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0000_0000};
    vt[3]  = '{1'b1, 32'h0000_000C, 4'h3, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0000};
    vt[4]  = '{1'b0, 32'h0000_000C, 4'hF, 32'h0,         1'b1, 1'b0, 32'hA5A5_1234};
    vt[5]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0002};
    vt[6]  = '{1'b1, 32'h0000_0024, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000};
    vt[7]  = '{1'b1, 32'h0000_0028, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000};
    vt[8]  = '{1'b0, 32'h0000_0028, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
    vt[9]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0002};
    vt[10] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0005};
    vt[11] = '{1'b1, 32'h0000_001C, 4'h8, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000};
    vt[12] = '{1'b0, 32'h0000_001C, 4'hF, 32'h0,         1'b1, 1'b0, 32'hDE00_0000};
    vt[13] = '{1'b1, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000};
    vt[14] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0000};
    vt[15] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0004};
    vt[16] = '{1'b1, 32'h0000_0020, 4'hF, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0000};
    vt[17] = '{1'b0, 32'h8000_0000, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
    vt[18] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0000_0009};
    vt[19] = '{1'b1, 32'h0000_0017, 4'h5, 32'h1122_3344, 1'b1, 1'b0, 32'h0000_0000};
    vt[20] = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0022_0044};

    // Reset: outputs low at the reset edge and on the following cycle.
    @(negedge p_clk);
    p_reset = 1'b1;
    @(posedge p_clk); #1;
    @(negedge p_clk);
    p_reset = 1'b0;
    chk("rst_out0", {bus0.ACK_O, bus0.ERR_O, bus0.DAT_O[29:0]}, 32'd0);
    chk("rst_out3", {bus3.ACK_O, bus3.ERR_O, bus3.DAT_O[29:0]}, 32'd0);
    @(posedge p_clk); #1;
    chk("rst_next0", {bus0.ACK_O, bus0.ERR_O, bus0.DAT_O[29:0]}, 32'd0);
    chk("rst_rty0", {31'd0, bus0.RTY_O}, 32'd0);

    // Table-driven vectors on the zero-wait-state instance.
    for (int i = 0; i < 21; i++) begin
      xfer(1'b0, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, a, e, d, l);
      chk($sformatf("v%0d_ack", i), {31'd0, a}, {31'd0, vt[i].ack});
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vt[i].err});
      chk($sformatf("v%0d_dat", i), d, vt[i].rdat);
      chk($sformatf("v%0d_lat", i), 32'(l), 32'd1);
    end

    // Back-to-back reads with STB held: ACK every second cycle, RCNT 0 -> 4.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(posedge p_clk); #1;
      chk($sformatf("b2b_ack_c%0d", c), {31'd0, bus0.ACK_O}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c == 6) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      end
    end
    rd_expect(1'b0, "b2b_rcnt", 32'h0000_0024, 32'd4, 1);

    // Three wait states: read latency is four cycles.
    do_reset();
    rd_expect(1'b1, "ws3_rd0", 32'h0000_0000, 32'h0, 4);

    // Write aborted by dropping CYC in the second wait cycle.
    @(negedge p_clk);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 4'hF, 32'h55AA_55AA);
    @(posedge p_clk); #1;
    chk("abort_w1", {30'd0, bus3.ACK_O, bus3.ERR_O}, 32'd0);
    @(posedge p_clk); #1;
    chk("abort_w2", {30'd0, bus3.ACK_O, bus3.ERR_O}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(posedge p_clk); #1;
      chk($sformatf("abort_quiet%0d", c), {30'd0, bus3.ACK_O, bus3.ERR_O}, 32'd0);
    end
    rd_expect(1'b1, "abort_reg2", 32'h0000_0008, 32'h0, 4);
    rd_expect(1'b1, "abort_wcnt", 32'h0000_0020, 32'd0, 4);
    rd_expect(1'b1, "abort_rcnt", 32'h0000_0024, 32'd3, 4);

    // Reset asserted while a write to index 1 sits in WAIT.
    @(negedge p_clk);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 4'hF, 32'hCAFE_F00D);
    @(posedge p_clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    p_reset = 1'b1;
    @(posedge p_clk); #1;
    chk("rstw_out", {30'd0, bus3.ACK_O, bus3.ERR_O}, 32'd0);
    @(negedge p_clk);
    p_reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge p_clk); #1;
      chk($sformatf("rstw_quiet%0d", c), {30'd0, bus3.ACK_O, bus3.ERR_O}, 32'd0);
    end
    rd_expect(1'b1, "rstw_reg1", 32'h0000_0004, 32'h0, 4);
    rd_expect(1'b1, "rstw_wcnt", 32'h0000_0020, 32'd0, 4);
    xfer(1'b1, 1'b1, 32'h0000_0004, 4'hF, 32'h1234_5678, a, e, d, l);
    chk("rstw_wr_ack", {31'd0, a}, 32'd1);
    chk("rstw_wr_lat", 32'(l), 32'd4);
    rd_expect(1'b1, "rstw_reg1b", 32'h0000_0004, 32'h1234_5678, 4);
    rd_expect(1'b1, "rstw_wcnt1", 32'h0000_0020, 32'd1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
